serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit integer subtractor for the Int_ALU: DIFF = A - B - BIN.
//   It is the inverse-direction counterpart of the combinational adder_4bit.

---
 rtl/serial_subtractor.sv | 161 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (DIFF = A - B - BIN), one difference bit per clock, LSB first.
// Optional signed-overflow output OVF is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
`ifdef SERIAL_SUB_OVF_EN
    output logic             OVF,
`endif
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic br);
        logic d;
        logic bo;
        d  = a ^ b ^ br;
        bo = (~a & b) | (~(a ^ b) & br);
        return {bo, d};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] dsh_q, dsh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [1:0]       cell_s;
    logic [WIDTH-1:0] dsh_next_s;

    assign cell_s     = sub_bit(a_q[0], b_q[0], br_q);
    assign dsh_next_s = {cell_s[0], dsh_q[WIDTH-1:1]};

    // Next-state and datapath update for the IDLE -> RUN -> FIN sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        dsh_d   = dsh_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_FIN: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = BIN;
                    dsh_d   = {WIDTH{1'b0}};
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = cell_s[1];
                dsh_d = dsh_next_s;
                if (cnt_q == CNT_LAST) begin
                    // On the last step a_q[0]/b_q[0] hold the operand MSBs.
                    cnt_d   = CNT_ZERO;
                    diff_d  = dsh_next_s;
                    bout_d  = cell_s[1];
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_q[0] != b_q[0]) && (cell_s[0] != a_q[0]);
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            dsh_q   <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            dsh_q   <= dsh_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign DIFF = diff_q;
    assign BOUT = bout_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
`ifdef SERIAL_SUB_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): directed vectors with hand-computed results.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         START = 1'b0;
    logic         BIN   = 1'b0;
    logic [W-1:0] A     = 4'b0000;
    logic [W-1:0] B     = 4'b0000;
    logic [W-1:0] DIFF;
    logic         BOUT;
    logic         BUSY;
    logic         DONE;
`ifdef SERIAL_SUB_OVF_EN
    logic         OVF;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .START (START),
        .A     (A),
        .B     (B),
        .BIN   (BIN),
`ifdef SERIAL_SUB_OVF_EN
        .OVF   (OVF),
`endif
        .DIFF  (DIFF),
        .BOUT  (BOUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse pops one expected result and compares it.
    always @(negedge clk) begin
        if (rst_n && DONE === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got DONE=1 expected no pending op");
            end else begin
                mon_e = sb.pop_front();
                chk("diff", {28'd0, DIFF}, {28'd0, mon_e.diff});
                chk("bout", {31'd0, BOUT}, {31'd0, mon_e.bout});
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", {31'd0, OVF}, {31'd0, mon_e.ovf});
`endif
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input exp_t e);
        A     = a;
        B     = b;
        BIN   = bin;
        START = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        START = 1'b0;
    endtask

    // Called #1 after the accept edge; returns #1 after the edge that raises DONE.
    task automatic run_wait(input string name);
        int n    = 0;
        int busy = 0;
        while (DONE !== 1'b1 && n < 20) begin
            if (BUSY === 1'b1) busy++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, n, W);
        chk({name, "_busy_cycles"}, busy, W);
    endtask

    task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bin, input exp_t e);
        issue(a, b, bin, e);
        run_wait(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        #12;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_diff", {28'd0, DIFF}, 32'd0);
        chk("rst_bout", {31'd0, BOUT}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op("t1",  4'b0111, 4'b0001, 1'b0, '{diff: 4'b0110, bout: 1'b0, ovf: 1'b0});
        op("t2",  4'b0010, 4'b0011, 1'b0, '{diff: 4'b1111, bout: 1'b1, ovf: 1'b0});
        op("t3a", 4'b0000, 4'b0000, 1'b1, '{diff: 4'b1111, bout: 1'b1, ovf: 1'b0});
        op("t3b", 4'b1111, 4'b1111, 1'b0, '{diff: 4'b0000, bout: 1'b0, ovf: 1'b0});
        op("t3c", 4'b0000, 4'b1000, 1'b0, '{diff: 4'b1000, bout: 1'b1, ovf: 1'b1});

        // Second START while busy must be ignored.
        d0 = done_cnt;
        issue(4'b1010, 4'b0011, 1'b0, '{diff: 4'b0111, bout: 1'b0, ovf: 1'b1});
        @(posedge clk);
        #1;
        A     = 4'b0000;
        START = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_done_count", done_cnt - d0, 32'd1);

        // Back-to-back: START in the FIN cycle.
        issue(4'b1100, 4'b0100, 1'b0, '{diff: 4'b1000, bout: 1'b0, ovf: 1'b0});
        run_wait("t5a");
        issue(4'b0101, 4'b0110, 1'b0, '{diff: 4'b1111, bout: 1'b1, ovf: 1'b0});
        chk("t5_done_drop", {31'd0, DONE}, 32'd0);
        chk("t5_busy_rise", {31'd0, BUSY}, 32'd1);
        run_wait("t5b");
        @(posedge clk);
        #1;

        // Reset mid-op: aborted op is never pushed, so any DONE is spurious.
        A     = 4'b0110;
        B     = 4'b0001;
        BIN   = 1'b0;
        START = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {31'd0, BUSY}, 32'd0);
        chk("t6_diff", {28'd0, DIFF}, 32'd0);
        chk("t6_bout", {31'd0, BOUT}, 32'd0);
        chk("t6_done", {31'd0, DONE}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - d0, 32'd0);
        op("t6b", 4'b1000, 4'b0001, 1'b0, '{diff: 4'b0111, bout: 1'b0, ovf: 1'b1});

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
